uart_alu_ctrl: RTL and testbench
================================

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, width of the UART byte, the ALU operands and the ALU result.
REQ-002 Parameter OP_W, default 6, width of the ALU opcode, taken from rx_dout[OP_W-1:0].
REQ-003 Parameter TIMEOUT_CYC, default 1000000, maximum clk cycles between bytes of one frame; used only with UART_FRAME_TIMEOUT_EN.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset.
REQ-005 clk  input  1  system clock, rising edge.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 rx_done_tick  input  1  one-cycle pulse from the UART receiver: byte valid on rx_dout.
REQ-008 rx_dout  input  DATA_W  received byte.
REQ-009 tx_done_tick  input  1  one-cycle pulse from the UART transmitter: byte sent.
REQ-010 tx_start  output  1  one-cycle request to the transmitter.
REQ-011 tx_din  output  DATA_W  byte to transmit, held stable from tx_start until tx_done_tick.
REQ-012 alu_a, alu_b  output  DATA_W each  registered ALU operands.
REQ-013 alu_op  output  OP_W  registered ALU opcode.
REQ-014 alu_result  input  DATA_W  combinational ALU result.
REQ-015 busy  output  1  high in EXEC and WAIT_TX.
REQ-016 drop_tick  output  1  one-cycle pulse when a received byte is discarded.
REQ-017 timeout_tick  output  1  one-cycle pulse when a partial frame is aborted.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT_B, WAIT_OP, EXEC and WAIT_TX; a frame is byte A, then byte B, then the opcode byte.
REQ-019 On rx_done_tick the FSM SHALL move as follows:
- IDLE: latch alu_a, go to WAIT_B.
- WAIT_B: latch alu_b, go to WAIT_OP.
- WAIT_OP: latch alu_op = rx_dout[OP_W-1:0], go to EXEC.
REQ-020 EXEC SHALL last exactly one cycle; on its closing edge tx_din <= alu_result, tx_start <= 1 and the state becomes WAIT_TX.
- tx_start is high exactly 2 cycles after the opcode's rx_done_tick cycle.
REQ-021 tx_start SHALL deassert on the cycle after it is asserted; it is never high for more than one cycle.
REQ-022 In WAIT_TX, tx_done_tick SHALL return the FSM to IDLE; tx_done_tick in any other state SHALL be ignored.
REQ-023 rx_done_tick in EXEC or WAIT_TX SHALL discard the byte, leave all registers unchanged and pulse drop_tick in the next cycle.
REQ-024 alu_a, alu_b and alu_op SHALL hold their values until overwritten by a later frame.
REQ-025 If rx_done_tick and tx_done_tick occur together in WAIT_TX, the byte SHALL be dropped and the FSM SHALL go to IDLE.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE and clear every output and register to 0, including mid-frame and mid-transmission.
REQ-027 After reset deassertion, the first rx_done_tick SHALL be treated as byte A.

Configuration
REQ-028 With UART_FRAME_TIMEOUT_EN defined, the block SHALL count clk cycles in WAIT_B and WAIT_OP.
- The counter clears on entry to those states and on every accepted byte.
- When the count reaches TIMEOUT_CYC-1, the FSM goes to IDLE and timeout_tick pulses for one cycle.
- alu_a and alu_b are not cleared on abort.
REQ-029 With UART_FRAME_TIMEOUT_EN defined, rx_done_tick in the terminal-count cycle SHALL win: the byte is accepted and no timeout occurs.
REQ-030 Without UART_FRAME_TIMEOUT_EN, no counter SHALL be built, timeout_tick SHALL be tied to 0 and the port SHALL still exist.

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state encoding and the defaults for DATA_W and OP_W.
REQ-032 The timeout counter SHALL be a sub-module uart_timeout_cnt (inputs clr and en; output expired), instantiated only under UART_FRAME_TIMEOUT_EN.

Verification
REQ-033 Bytes 0x05, 0x03, 0x20 with the ALU stub returning 0x08 -> alu_a=0x05, alu_b=0x03, alu_op=0x20; tx_din=0x08; tx_start one pulse 2 cycles after the 3rd tick; busy until tx_done_tick.
REQ-034 Opcode byte 0xE7 -> alu_op=0x27.
REQ-035 A 4th byte 0x11 arrives during WAIT_TX -> drop_tick pulses once; alu_a remains 0x05; the FSM is IDLE after tx_done_tick.
REQ-036 Reset asserted in WAIT_OP after bytes 0xAA, 0xBB -> all outputs 0 immediately; the next three bytes form a fresh frame.
REQ-037 With UART_FRAME_TIMEOUT_EN and TIMEOUT_CYC=16, byte 0x01 followed by 16 idle cycles -> timeout_tick pulses once and the FSM is IDLE.
- A byte arriving on cycle 15 instead is accepted as B.
REQ-038 Simultaneous rx_done_tick (0x44) and tx_done_tick in WAIT_TX -> drop_tick pulses, the FSM is IDLE and alu_a is unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared definitions for the UART-driven ALU controller:
//             FSM state encoding, default widths and state helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default byte / operand / result width and opcode width.
    localparam int UART_DATA_W = 8;
    localparam int UART_OP_W   = 6;

    // Frame-sequencing FSM: A byte, B byte, opcode byte, execute, transmit.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_t;

    // The controller is busy once a full frame has been received.
    function automatic logic state_is_busy(input state_t s);
        return (s == ST_EXEC) || (s == ST_WAIT_TX);
    endfunction

    // States in which a partially received frame is pending.
    function automatic logic state_is_partial(input state_t s);
        return (s == ST_WAIT_B) || (s == ST_WAIT_OP);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : uart_timeout_cnt
//  Brief    : Inter-byte cycle counter for partial-frame abort. expired is
//             high while enabled and the count sits at TIMEOUT_CYC-1.
//             Only built when UART_FRAME_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef UART_FRAME_TIMEOUT_EN
module uart_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = en && (cnt_q == CNT_TERM);

    // Next count: clear wins, otherwise advance while enabled and hold at terminal.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_timeout_cnt
`endif
`default_nettype wire

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_alu_ctrl
//  Brief    : Collects a 3-byte frame (A, B, opcode) from a UART receiver,
//             presents registered operands to an external ALU, and sends the
//             ALU result back through the UART transmitter.
//             Optional feature macro: UART_FRAME_TIMEOUT_EN (aborts a partial
//             frame after TIMEOUT_CYC idle cycles; timeout_tick tied low
//             when undefined).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W      = UART_DATA_W,
    parameter int OP_W        = UART_OP_W,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [DATA_W-1:0] rx_dout,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_din,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic              drop_tick,
    output logic              timeout_tick
);

    // Reject configurations the opcode slice and the counter cannot support.
    if (OP_W > DATA_W || OP_W < 1 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_alu_ctrl: need 1 <= OP_W <= DATA_W and TIMEOUT_CYC >= 2");
    end

    state_t              state_q,    state_d;
    logic [DATA_W-1:0]   alu_a_q,    alu_a_d;
    logic [DATA_W-1:0]   alu_b_q,    alu_b_d;
    logic [OP_W-1:0]     alu_op_q,   alu_op_d;
    logic [DATA_W-1:0]   tx_din_q,   tx_din_d;
    logic                tx_start_q, tx_start_d;
    logic                drop_q,     drop_d;
    logic                w_abort;

`ifdef UART_FRAME_TIMEOUT_EN
    logic w_partial;
    logic w_accept;
    logic w_expired;
    logic timeout_q;

    assign w_partial = state_is_partial(state_q);
    assign w_accept  = rx_done_tick && !state_is_busy(state_q);

    // Counter restarts on entry to a partial-frame state and on every accepted byte.
    uart_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (!w_partial || w_accept),
        .en      (w_partial),
        .expired (w_expired)
    );

    // A byte landing on the terminal-count cycle takes priority over the abort.
    assign w_abort = w_partial && w_expired && !rx_done_tick;

    // Timeout pulse, one cycle after the abort decision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= w_abort;
        end
    end

    assign timeout_tick = timeout_q;
`else
    assign w_abort      = 1'b0;
    assign timeout_tick = 1'b0;
`endif

    // Frame sequencing: byte capture, execute, transmit hand-off and drops.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_din_d   = tx_din_q;
        tx_start_d = 1'b0;
        drop_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_done_tick) begin
                    alu_a_d = rx_dout;
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (rx_done_tick) begin
                    alu_b_d = rx_dout;
                    state_d = ST_WAIT_OP;
                end else if (w_abort) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_OP: begin
                if (rx_done_tick) begin
                    alu_op_d = rx_dout[OP_W-1:0];
                    state_d  = ST_EXEC;
                end else if (w_abort) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // Operands have been stable for a full cycle; capture the result.
                tx_din_d   = alu_result;
                tx_start_d = 1'b1;
                state_d    = ST_WAIT_TX;
                drop_d     = rx_done_tick;
            end
            ST_WAIT_TX: begin
                drop_d = rx_done_tick;
                if (tx_done_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_din_q   <= '0;
            tx_start_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_din_q   <= tx_din_d;
            tx_start_q <= tx_start_d;
            drop_q     <= drop_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign tx_din    = tx_din_q;
    assign tx_start  = tx_start_q;
    assign drop_tick = drop_q;
    assign busy      = state_is_busy(state_q);

endmodule : uart_alu_ctrl
`default_nettype wire

// File: tb/tb_uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_alu_ctrl
//  Brief    : Self-checking bench for uart_alu_ctrl: directed frames, drops,
//             reset mid-frame, simultaneous rx/tx ticks, randomized frames
//             and (with UART_FRAME_TIMEOUT_EN) partial-frame timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_alu_ctrl;

    localparam int DATA_W      = 8;
    localparam int OP_W        = 6;
    localparam int TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx_done_tick = 1'b0;
    logic [DATA_W-1:0] rx_dout = '0;
    logic              tx_done_tick = 1'b0;
    logic              tx_start;
    logic [DATA_W-1:0] tx_din;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              busy;
    logic              drop_tick;
    logic              timeout_tick;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_alu_ctrl #(
        .DATA_W      (DATA_W),
        .OP_W        (OP_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .busy         (busy),
        .drop_tick    (drop_tick),
        .timeout_tick (timeout_tick)
    );

    // Small ALU: low two opcode bits pick add / sub / and / xor.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // ALU stub driven from the registered operands.
    always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_dout      = b;
        step();
        rx_done_tick = 1'b0;
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 3)) step();
    endtask

    // From the opcode byte to the end of transmission.
    // mode 0: plain; 1: extra byte dropped in WAIT_TX; 2: extra byte with tx_done together.
    task automatic finish_frame(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] opb, input int mode, input logic [7:0] xb);
        logic [7:0] exp_tx;
        exp_tx = alu_fn(a, b, opb[5:0]);
        send_byte(opb);
        chk("op_latch", alu_op, opb & 8'h3F);
        chk("exec_busy", busy, 1);
        chk("exec_tx_start", tx_start, 0);
        step();
        chk("tx_start_pulse", tx_start, 1);
        chk("tx_din", tx_din, exp_tx);
        chk("wait_busy", busy, 1);
        step();
        chk("tx_start_low", tx_start, 0);
        if (mode == 1) begin
            send_byte(xb);
            chk("drop_pulse", drop_tick, 1);
            chk("drop_keep_a", alu_a, a);
            chk("drop_keep_b", alu_b, b);
            step();
            chk("drop_once", drop_tick, 0);
            chk("drop_busy", busy, 1);
            chk("drop_tx_din", tx_din, exp_tx);
        end
        repeat ($urandom_range(0, 3)) step();
        chk("hold_tx_din", tx_din, exp_tx);
        tx_done_tick = 1'b1;
        if (mode == 2) begin
            rx_done_tick = 1'b1;
            rx_dout      = xb;
        end
        step();
        tx_done_tick = 1'b0;
        rx_done_tick = 1'b0;
        chk("done_idle", busy, 0);
        if (mode == 2) begin
            chk("sim_drop", drop_tick, 1);
            chk("sim_keep_a", alu_a, a);
        end
        step();
        chk("no_drop", drop_tick, 0);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] opb, input int mode, input logic [7:0] xb);
        send_byte(a);
        chk("a_latch", alu_a, a);
        chk("a_busy", busy, 0);
        idle_gap();
        send_byte(b);
        chk("b_latch", alu_b, b);
        chk("b_keep_a", alu_a, a);
        idle_gap();
        finish_frame(a, b, opb, mode, xb);
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb, ro, rx;
        int         rmode;

        // Reset state.
        repeat (3) step();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_din", tx_din, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_tick, 0);
        chk("rst_timeout", timeout_tick, 0);
        reset = 1'b1;
        step();

        // Basic frame: 5 + 3 = 8, then a 4th byte dropped while transmitting.
        run_frame(8'h05, 8'h03, 8'h20, 1, 8'h11);
        chk("after_drop_a", alu_a, 8'h05);

        // tx_done outside WAIT_TX is ignored.
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("stray_tx_done", busy, 0);

        // Opcode upper bits are stripped: 0xE7 -> 0x27 (xor).
        run_frame(8'h3C, 8'h0F, 8'hE7, 0, 8'h00);

        // Reset in WAIT_OP clears everything without a clock edge.
        send_byte(8'hAA);
        send_byte(8'hBB);
        chk("pre_rst_a", alu_a, 8'hAA);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_a", alu_a, 0);
        chk("async_rst_b", alu_b, 0);
        chk("async_rst_op", alu_op, 0);
        chk("async_rst_tx_din", tx_din, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_tx_start", tx_start, 0);
        step();
        reset = 1'b1;
        step();
        run_frame(8'h12, 8'h34, 8'h01, 0, 8'h00);

        // Simultaneous rx and tx_done in WAIT_TX.
        run_frame(8'h77, 8'h22, 8'h02, 2, 8'h44);
        run_frame(8'h81, 8'h7F, 8'h00, 0, 8'h00);

        // Randomized frames against the frame-level model.
        for (int i = 0; i < 20; i++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            ro    = 8'($urandom);
            rx    = 8'($urandom);
            rmode = int'($urandom_range(0, 2));
            run_frame(ra, rb, ro, rmode, rx);
        end

`ifdef UART_FRAME_TIMEOUT_EN
        // Byte A then TIMEOUT_CYC idle cycles -> abort.
        send_byte(8'h01);
        repeat (TIMEOUT_CYC - 1) step();
        chk("to_not_yet", timeout_tick, 0);
        step();
        chk("to_pulse", timeout_tick, 1);
        chk("to_idle_busy", busy, 0);
        chk("to_keep_a", alu_a, 8'h01);
        step();
        chk("to_once", timeout_tick, 0);
        run_frame(8'h5A, 8'h06, 8'h01, 0, 8'h00);

        // Byte on the terminal-count cycle wins.
        send_byte(8'h01);
        repeat (TIMEOUT_CYC - 1) step();
        send_byte(8'h22);
        chk("tc_b_accept", alu_b, 8'h22);
        chk("tc_no_timeout", timeout_tick, 0);
        step();
        chk("tc_no_timeout2", timeout_tick, 0);
        finish_frame(8'h01, 8'h22, 8'h00, 0, 8'h00);
`else
        // Without the timeout feature a long gap does not abort the frame.
        send_byte(8'h01);
        repeat (3 * TIMEOUT_CYC) step();
        chk("nto_tick", timeout_tick, 0);
        send_byte(8'h22);
        chk("nto_b_accept", alu_b, 8'h22);
        chk("nto_keep_a", alu_a, 8'h01);
        finish_frame(8'h01, 8'h22, 8'h00, 0, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_alu_ctrl
`default_nettype wire
